cpu: RTL and testbench
======================

CPU -- requirements
Module: cpu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Constant ADD, 3'd0: ALU add.
REQ-003 Constant SUB, 3'd1: ALU subtract.
REQ-004 Constant AND, 3'd2: ALU bitwise and.
REQ-005 Constant OR, 3'd3: ALU bitwise or.
REQ-006 Constant XOR, 3'd4: ALU bitwise xor.
REQ-007 Constant SLL, 3'd5: ALU shift left logical.
REQ-008 Constant SRL, 3'd6: ALU shift right logical.
REQ-009 Constant SLT, 3'd7: ALU signed set-less-than.
REQ-010 clk  in  1  rising-edge clock.
REQ-011 reset  in  1  synchronous reset; active when 0.
REQ-012 initial_instructions  in  32x32  ROM contents, word i at byte address 4i.
REQ-013 initial_register_values  in  32x32  register values loaded at reset.
REQ-014 pc_out_check  out  32  current PC.
REQ-015 instruction_check  out  32  fetched instruction.
REQ-016 alu_op_check  out  3  decoded ALU op.
REQ-017 register_data_out1_check / register_data_out2_check  out  32 each  rs1 / rs2 read data.
REQ-018 b_input_check  out  32  ALU B operand after the immediate mux.
REQ-019 imm_ext_check  out  32  sign-extended I-immediate.
REQ-020 use_imm_check  out  1  B operand is the immediate.
REQ-021 alu_result_check  out  32  ALU result.
REQ-022 register_data_in_check  out  32  write-back data, equal to the ALU result.
REQ-023 reg_write_check  out  1  write-back enable.
REQ-024 register_check  out  32x32  live contents of all registers.

Function
REQ-025 Submodules alu and instruction_memory SHALL be separate modules instantiated inside cpu.
- alu: combinational; inputs a, b, alu_op; output result.
- instruction_memory: combinational; inputs pc, initial_instructions; output instruction.
REQ-026 Instruction fetch SHALL be combinational: instruction = initial_instructions[pc[6:2]]; the address wraps modulo 32 words and pc[1:0] is ignored.
REQ-027 Register reads SHALL be combinational; x0 SHALL read 0, and writes to x0 SHALL be discarded.
REQ-028 Immediate: imm_ext = {20{instr[31]}, instr[31:20]}.
REQ-029 R-type (opcode 0110011) decode, with use_imm=0 and reg_write=1:
- funct3 000: SUB if funct7=0100000, otherwise ADD.
- funct3 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL, 010 SLT.
- funct3 011: treated as SLT.
REQ-030 I-type ALU (opcode 0010011) decode, with use_imm=1 and reg_write=1:
- Same funct3 map as R-type; funct3 000 is always ADD.
- Shift amount = imm[4:0].
REQ-031 Any other opcode SHALL set reg_write=0, use_imm=0 and alu_op=ADD; the PC still advances (NOP).
REQ-032 ALU arithmetic is modulo 2^32; shifts use b[4:0]; SLT compares signed and returns 1 or 0.
REQ-033 On each rising edge with reset=1, the block SHALL, in a single cycle:
- write alu_result to rd if reg_write=1 and rd≠0;
- set pc <= pc+4, wrapping modulo 2^32.
REQ-034 All debug outputs SHALL be combinational views of current state and decode.

Reset
REQ-035 On a rising edge with reset=0:
- pc <= 0;
- registers x1..x31 <= initial_register_values[1..31];
- x0 <= 0;
- no write-back occurs.
REQ-036 After reset, outputs SHALL reflect instruction word 0; reset asserted mid-program SHALL restart identically on the next edge.

Verification
REQ-037 Reset scenario:
- Stimulus: registers 3000+i; ROM = 0x005303b3, 0x40848533, 0x00160693, then zeros; one reset edge.
- Response: pc=0, instruction 0x005303b3, ADD, out1=3006, out2=3005, result=6011, use_imm=0.
REQ-038 Next edge -> x7=6011, pc=4, instruction 0x40848533, SUB, out1=3009, out2=3008, result=1.
REQ-039 Next edge -> pc=8, ADD, imm_ext=1, use_imm=1, out1=3012, b_input=1, result=3013; one further edge -> x13=3013.
REQ-040 ALU with a=4, b=2:
- ADD=6, SUB=2, AND=0, OR=6, XOR=6, SLL=16, SRL=1, SLT=0.
- Also a=0xFFFFFFFF, b=1, SLT -> 1.
REQ-041 Immediate 0xAAA -> imm_ext 0xFFFFFAAA; 0x555 -> 0x00000555; a write to x0 leaves register_check[0]=0.
REQ-042 Reset asserted after two instructions -> pc=0, x7=3007, x10=3010 restored.

Source files
------------

// File: rtl/cpu_if.sv
// Bundle of the CPU's program/register preload inputs and its debug views.
//   master: testbench side, drives initial_instructions / initial_register_values
//           and observes every *_check signal.
//   slave : cpu side, the mirror image.
// 32x32 arrays are packed so that element [i] is word / register i.
interface cpu_if;
    logic [31:0][31:0] initial_instructions;
    logic [31:0][31:0] initial_register_values;

    logic [31:0]       pc_out_check;
    logic [31:0]       instruction_check;
    logic [2:0]        alu_op_check;
    logic [31:0]       register_data_out1_check;
    logic [31:0]       register_data_out2_check;
    logic [31:0]       b_input_check;
    logic [31:0]       imm_ext_check;
    logic              use_imm_check;
    logic [31:0]       alu_result_check;
    logic [31:0]       register_data_in_check;
    logic              reg_write_check;
    logic [31:0][31:0] register_check;

    modport master (
        output initial_instructions, initial_register_values,
        input  pc_out_check, instruction_check, alu_op_check,
               register_data_out1_check, register_data_out2_check, b_input_check,
               imm_ext_check, use_imm_check, alu_result_check, register_data_in_check,
               reg_write_check, register_check
    );

    modport slave (
        input  initial_instructions, initial_register_values,
        output pc_out_check, instruction_check, alu_op_check,
               register_data_out1_check, register_data_out2_check, b_input_check,
               imm_ext_check, use_imm_check, alu_result_check, register_data_in_check,
               reg_write_check, register_check
    );
endinterface

// File: rtl/cpu.sv
// Single-cycle RV32I-subset CPU executing R-type and I-type ALU instructions.
//   alu                : combinational; a, b, alu_op -> result.
//   instruction_memory : combinational ROM view; pc, initial_instructions -> instruction.
//   cpu                : clk, reset (synchronous, active low), bus (cpu_if.slave) carrying the
//                        ROM / register preload and all debug views of state and decode.
// Any opcode other than 0110011 / 0010011 executes as a NOP.

module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alu_op,
    output logic [31:0] result
);
    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpSll = 3'd5;
    localparam logic [2:0] OpSrl = 3'd6;
    localparam logic [2:0] OpSlt = 3'd7;

    always_comb begin
        result = '0;
        unique case (alu_op)
            OpAdd: result = a + b;
            OpSub: result = a - b;
            OpAnd: result = a & b;
            OpOr:  result = a | b;
            OpXor: result = a ^ b;
            OpSll: result = a << b[4:0];
            OpSrl: result = a >> b[4:0];
            OpSlt: result = {31'b0, $signed(a) < $signed(b)};
            default: result = '0;
        endcase
    end
endmodule

module instruction_memory (
    input  logic [31:0]       pc,
    input  logic [31:0][31:0] initial_instructions,
    output logic [31:0]       instruction
);
    // Word-addressed, wraps every 32 words; byte offset bits are ignored.
    assign instruction = initial_instructions[pc[6:2]];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[31:7], pc[1:0]};
endmodule

module cpu (
    input  logic  clk,
    input  logic  reset,
    cpu_if.slave  bus
);
    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpSll = 3'd5;
    localparam logic [2:0] OpSrl = 3'd6;
    localparam logic [2:0] OpSlt = 3'd7;

    localparam logic [6:0] OpcodeR = 7'b0110011;
    localparam logic [6:0] OpcodeI = 7'b0010011;

    logic [31:0]       pc_q;
    logic [31:0][31:0] regs_q;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_ext;
    logic [31:0] rdata1, rdata2, b_input, alu_result;
    logic [2:0]  alu_op;
    logic        use_imm, reg_write;

    instruction_memory u_imem (
        .pc                   (pc_q),
        .initial_instructions (bus.initial_instructions),
        .instruction          (instr)
    );

    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign funct7  = instr[31:25];
    assign imm_ext = {{20{instr[31]}}, instr[31:20]};

    // funct3 011 (SLTU in RV32I) deliberately decodes as signed SLT.
    function automatic logic [2:0] funct3_to_op(input logic [2:0] f3);
        logic [2:0] op;
        op = OpAdd;
        unique case (f3)
            3'b000: op = OpAdd;
            3'b001: op = OpSll;
            3'b010: op = OpSlt;
            3'b011: op = OpSlt;
            3'b100: op = OpXor;
            3'b101: op = OpSrl;
            3'b110: op = OpOr;
            3'b111: op = OpAnd;
            default: op = OpAdd;
        endcase
        return op;
    endfunction

    always_comb begin
        alu_op    = OpAdd;
        use_imm   = 1'b0;
        reg_write = 1'b0;
        if (opcode == OpcodeR) begin
            reg_write = 1'b1;
            alu_op    = funct3_to_op(funct3);
            if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                alu_op = OpSub;
            end
        end else if (opcode == OpcodeI) begin
            reg_write = 1'b1;
            use_imm   = 1'b1;
            alu_op    = funct3_to_op(funct3);
        end
    end

    assign rdata1  = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rdata2  = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
    assign b_input = use_imm ? imm_ext : rdata2;

    alu u_alu (
        .a      (rdata1),
        .b      (b_input),
        .alu_op (alu_op),
        .result (alu_result)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q      <= 32'd0;
            regs_q    <= bus.initial_register_values;
            regs_q[0] <= 32'd0;
        end else begin
            pc_q <= pc_q + 32'd4;
            if (reg_write && rd != 5'd0) begin
                regs_q[rd] <= alu_result;
            end
        end
    end

    assign bus.pc_out_check             = pc_q;
    assign bus.instruction_check        = instr;
    assign bus.alu_op_check             = alu_op;
    assign bus.register_data_out1_check = rdata1;
    assign bus.register_data_out2_check = rdata2;
    assign bus.b_input_check            = b_input;
    assign bus.imm_ext_check            = imm_ext;
    assign bus.use_imm_check            = use_imm;
    assign bus.alu_result_check         = alu_result;
    assign bus.register_data_in_check   = alu_result;
    assign bus.reg_write_check          = reg_write;
    assign bus.register_check           = regs_q;
endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: expectations are queued before each clock edge and popped
// against the DUT's debug views 1 time unit after the edge.
module tb_cpu;
    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpSll = 3'd5;
    localparam logic [2:0] OpSrl = 3'd6;
    localparam logic [2:0] OpSlt = 3'd7;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cpu_if bus ();

    cpu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    string       exp_tags[$];
    logic [31:0] exp_vals[$];

    logic [31:0] rom2 [16];
    logic [2:0]  ops  [16];
    logic [31:0] res  [16];

    function automatic logic [31:0] r_enc(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_enc(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_tags.push_back(tag);
        exp_vals.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        checks++;
        if (exp_vals.size() == 0) begin
            tag = "empty_scoreboard";
            exp = 32'hxxxx_xxxx;
        end else begin
            tag = exp_tags.pop_front();
            exp = exp_vals.pop_front();
        end
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_state(input logic [31:0] pc, input logic [31:0] instr,
                             input logic [2:0] op, input logic [31:0] result);
        expect_val("pc", pc);
        expect_val("instruction", instr);
        expect_val("alu_op", 32'(op));
        expect_val("alu_result", result);
        expect_val("data_in", result);
    endtask

    task automatic chk_state();
        check(bus.pc_out_check);
        check(bus.instruction_check);
        check(32'(bus.alu_op_check));
        check(bus.alu_result_check);
        check(bus.register_data_in_check);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Program A: registers 3000+i, three-instruction program.
        for (int i = 0; i < 32; i++) begin
            bus.initial_register_values[i] = 32'(3000 + i);
            bus.initial_instructions[i]    = 32'd0;
        end
        bus.initial_instructions[0] = 32'h005303b3;
        bus.initial_instructions[1] = 32'h40848533;
        bus.initial_instructions[2] = 32'h00160693;

        reset = 1'b0;
        exp_state(32'd0, 32'h005303b3, OpAdd, 32'd6011);
        expect_val("out1", 32'd3006);
        expect_val("out2", 32'd3005);
        expect_val("b_input", 32'd3005);
        expect_val("use_imm", 32'd0);
        expect_val("reg_write", 32'd1);
        expect_val("x0_reset", 32'd0);
        step();
        reset = 1'b1;
        chk_state();
        check(bus.register_data_out1_check);
        check(bus.register_data_out2_check);
        check(bus.b_input_check);
        check(32'(bus.use_imm_check));
        check(32'(bus.reg_write_check));
        check(bus.register_check[0]);

        exp_state(32'd4, 32'h40848533, OpSub, 32'd1);
        expect_val("x7", 32'd6011);
        expect_val("out1", 32'd3009);
        expect_val("out2", 32'd3008);
        step();
        chk_state();
        check(bus.register_check[7]);
        check(bus.register_data_out1_check);
        check(bus.register_data_out2_check);

        exp_state(32'd8, 32'h00160693, OpAdd, 32'd3013);
        expect_val("imm_ext", 32'd1);
        expect_val("use_imm", 32'd1);
        expect_val("out1", 32'd3012);
        expect_val("b_input", 32'd1);
        expect_val("x10", 32'd1);
        step();
        chk_state();
        check(bus.imm_ext_check);
        check(32'(bus.use_imm_check));
        check(bus.register_data_out1_check);
        check(bus.b_input_check);
        check(bus.register_check[10]);

        expect_val("pc", 32'd12);
        expect_val("x13", 32'd3013);
        expect_val("nop_reg_write", 32'd0);
        step();
        check(bus.pc_out_check);
        check(bus.register_check[13]);
        check(32'(bus.reg_write_check));

        // Mid-program reset restores preload values.
        reset = 1'b0;
        expect_val("pc_rst", 32'd0);
        expect_val("instr_rst", 32'h005303b3);
        expect_val("x7_rst", 32'd3007);
        expect_val("x10_rst", 32'd3010);
        expect_val("x13_rst", 32'd3013);
        step();
        check(bus.pc_out_check);
        check(bus.instruction_check);
        check(bus.register_check[7]);
        check(bus.register_check[10]);
        check(bus.register_check[13]);

        // Program B: every ALU op, immediates, x0 write, NOP, wrap-around.
        for (int i = 0; i < 32; i++) begin
            bus.initial_register_values[i] = 32'd0;
            bus.initial_instructions[i]    = 32'd0;
        end
        bus.initial_register_values[1] = 32'd4;
        bus.initial_register_values[2] = 32'd2;
        bus.initial_register_values[3] = 32'hFFFF_FFFF;
        bus.initial_register_values[4] = 32'd1;

        rom2[0]  = r_enc(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd5); ops[0]  = OpAdd; res[0]  = 32'd6;
        rom2[1]  = r_enc(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd5); ops[1]  = OpSub; res[1]  = 32'd2;
        rom2[2]  = r_enc(7'b0000000, 5'd2, 5'd1, 3'b111, 5'd5); ops[2]  = OpAnd; res[2]  = 32'd0;
        rom2[3]  = r_enc(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd5); ops[3]  = OpOr;  res[3]  = 32'd6;
        rom2[4]  = r_enc(7'b0000000, 5'd2, 5'd1, 3'b100, 5'd5); ops[4]  = OpXor; res[4]  = 32'd6;
        rom2[5]  = r_enc(7'b0000000, 5'd2, 5'd1, 3'b001, 5'd5); ops[5]  = OpSll; res[5]  = 32'd16;
        rom2[6]  = r_enc(7'b0000000, 5'd2, 5'd1, 3'b101, 5'd5); ops[6]  = OpSrl; res[6]  = 32'd1;
        rom2[7]  = r_enc(7'b0000000, 5'd2, 5'd1, 3'b010, 5'd5); ops[7]  = OpSlt; res[7]  = 32'd0;
        rom2[8]  = r_enc(7'b0000000, 5'd4, 5'd3, 3'b010, 5'd5); ops[8]  = OpSlt; res[8]  = 32'd1;
        rom2[9]  = r_enc(7'b0000000, 5'd4, 5'd3, 3'b011, 5'd5); ops[9]  = OpSlt; res[9]  = 32'd1;
        rom2[10] = i_enc(12'hAAA, 5'd0, 3'b000, 5'd6); ops[10] = OpAdd; res[10] = 32'hFFFF_FAAA;
        rom2[11] = i_enc(12'h555, 5'd0, 3'b000, 5'd6); ops[11] = OpAdd; res[11] = 32'h0000_0555;
        rom2[12] = i_enc(12'h005, 5'd1, 3'b000, 5'd0); ops[12] = OpAdd; res[12] = 32'd9;
        rom2[13] = 32'd0;                              ops[13] = OpAdd; res[13] = 32'd0;
        rom2[14] = i_enc(12'h001, 5'd1, 3'b101, 5'd6); ops[14] = OpSrl; res[14] = 32'd2;
        rom2[15] = i_enc(12'h003, 5'd1, 3'b001, 5'd6); ops[15] = OpSll; res[15] = 32'd32;
        for (int i = 0; i < 16; i++) bus.initial_instructions[i] = rom2[i];

        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_state(32'(4 * i), rom2[i], ops[i], res[i]);
            if (i >= 1 && i <= 10) expect_val("x5", res[i - 1]);
            if (i == 10) begin
                expect_val("imm_neg", 32'hFFFF_FAAA);
                expect_val("use_imm_i", 32'd1);
            end
            if (i == 11) expect_val("imm_pos", 32'h0000_0555);
            if (i == 12) expect_val("x6", 32'h0000_0555);
            if (i == 13) begin
                expect_val("x0_write", 32'd0);
                expect_val("nop_reg_write", 32'd0);
                expect_val("nop_use_imm", 32'd0);
            end
            step();
            reset = 1'b1;
            chk_state();
            if (i >= 1 && i <= 10) check(bus.register_check[5]);
            if (i == 10) begin
                check(bus.imm_ext_check);
                check(32'(bus.use_imm_check));
            end
            if (i == 11) check(bus.imm_ext_check);
            if (i == 12) check(bus.register_check[6]);
            if (i == 13) begin
                check(bus.register_check[0]);
                check(32'(bus.reg_write_check));
                check(32'(bus.use_imm_check));
            end
        end

        // pc = 60 now; 17 more edges reach byte 128, which aliases word 0.
        expect_val("x6_sll", 32'd32);
        expect_val("pc_wrap", 32'd128);
        expect_val("instr_wrap", rom2[0]);
        for (int i = 0; i < 17; i++) step();
        check(bus.register_check[6]);
        check(bus.pc_out_check);
        check(bus.instruction_check);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
